// File: rtl/sprite_frame_writer.sv
// Sprite frame writer: streams one raster-ordered sprite frame into sprite RAM,
// writing each pixel twice -- once into the right-facing bank at its natural
// position and once into the left-facing bank horizontally mirrored.
//
// Handshake: a pixel is transferred on a rising edge where pixelValid and
// pixelReady are both high. pixelReady depends only on state (high in WR_RIGHT),
// so the source may hold pixelValid high across WR_LEFT cycles without loss.
module sprite_frame_writer #(
  parameter int playerWidth  = 44,
  parameter int playerHeight = 72,
  parameter int numFrames    = 5,
  parameter int leftOffset   = 15840
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [2:0]  frameIndex,
  input  logic [7:0]  pixelData,
  input  logic        pixelValid,
  output logic        pixelReady,
  output logic        memWe,
  output logic [20:0] memAddr,
  output logic [7:0]  memData,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR_RIGHT = 2'd1;
  localparam logic [1:0] S_WR_LEFT  = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam int CW = (playerWidth  > 1) ? $clog2(playerWidth)  : 1;
  localparam int RW = (playerHeight > 1) ? $clog2(playerHeight) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(playerWidth - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(playerHeight - 1);
  localparam logic [3:0]    FRAMES     = 4'(numFrames);
  localparam logic [20:0]   FRAME_SIZE = 21'(playerWidth * playerHeight);
  localparam logic [20:0]   WIDTH_W    = 21'(playerWidth);
  localparam logic [20:0]   LEFT_BASE  = 21'(leftOffset);

  logic [1:0]    state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [20:0]   base;
  logic [7:0]    pix;

  logic [20:0]   row_off;
  logic [CW-1:0] mirror_col;
  logic [20:0]   addr_right;
  logic [20:0]   addr_left;
  logic          transfer;
  logic          legal_index;

  // Status outputs and address arithmetic, all derived from current state.
  always_comb begin
    pixelReady  = (state == S_WR_RIGHT);
    busy        = (state != S_IDLE);
    state_dbg   = state;
    transfer    = pixelValid & pixelReady;
    legal_index = ({1'b0, frameIndex} < FRAMES);
    row_off     = 21'(row) * WIDTH_W;
    mirror_col  = COL_LAST - col;
    addr_right  = base + row_off + 21'(col);
    addr_left   = LEFT_BASE + base + row_off + 21'(mirror_col);
  end

  // Frame sequencer: right-bank write on transfer, mirrored left-bank write next.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      base    <= '0;
      pix     <= '0;
      memWe   <= 1'b0;
      memAddr <= '0;
      memData <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      memWe <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (legal_index) begin
              base  <= 21'(frameIndex) * FRAME_SIZE;
              row   <= '0;
              col   <= '0;
              error <= 1'b0;
              state <= S_WR_RIGHT;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_WR_RIGHT: begin
          if (transfer) begin
            memWe   <= 1'b1;
            memAddr <= addr_right;
            memData <= pixelData;
            pix     <= pixelData;
            state   <= S_WR_LEFT;
          end
        end
        S_WR_LEFT: begin
          memWe   <= 1'b1;
          memAddr <= addr_left;
          memData <= pix;
          if (col != COL_LAST) begin
            col   <= col + 1'b1;
            state <= S_WR_RIGHT;
          end else begin
            col <= '0;
            if (row == ROW_LAST) begin
              row   <= '0;
              state <= S_DONE;
            end else begin
              row   <= row + 1'b1;
              state <= S_WR_RIGHT;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
